// File: rtl/freq_meter.sv
`timescale 1ns/1ps
// freq_meter: counts rising edges of an asynchronous square wave over a gate
// window of GATE_CYCLES clk cycles and publishes the count once per window.
// With a 100 MHz clk and the default window, freq reads directly in Hz.
module freq_meter #(
  parameter int GATE_CYCLES = 100000000,
  parameter int COUNT_W     = 27
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               sig_in,
  output logic [COUNT_W-1:0] freq,
  output logic               valid,
  output logic               overflow,
  output logic               busy
);

  localparam int                 GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] EDGE_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [1:0]         r_sync;
  logic               r_hist;
  logic [2:0]         r_sync_vld;
  logic [GATE_W-1:0]  r_gate_cnt;
  logic [COUNT_W-1:0] r_edge_cnt;
  logic               r_sat;
  logic [COUNT_W-1:0] r_freq;
  logic               r_valid;
  logic               r_overflow;
  logic               w_rise;
  logic               w_gate_done;

  // Synchronize sig_in and keep one history flop for edge detection. The
  // r_sync_vld shadow pipeline marks when r_hist holds a real post-reset
  // sample, so a level that is already high at reset release is not
  // mistaken for a rising edge.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, forming a true shift chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync     <= '0;
      r_hist     <= 1'b0;
      r_sync_vld <= '0;
    end else begin
      r_sync     <= {r_sync[0], sig_in};
      r_hist     <= r_sync[1];
      r_sync_vld <= {r_sync_vld[1:0], 1'b1};
    end
  end

  assign w_rise      = r_sync[1] & ~r_hist & r_sync_vld[2];
  assign w_gate_done = (r_gate_cnt == GATE_LAST);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next-state logic; dropping enable during a window aborts it.
  // NOTE: the default assignment at the top keeps this block free of latches.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_next_state = S_COUNT;
      S_COUNT: begin
        if (!enable)          w_next_state = S_IDLE;
        else if (w_gate_done) w_next_state = S_LATCH;
      end
      S_LATCH: w_next_state = enable ? S_COUNT : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Gate/edge counters and the published result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
      r_freq     <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_COUNT: begin
          r_gate_cnt <= r_gate_cnt + 1'b1;
          if (w_rise) begin
            // Saturate rather than wrap; remember that an edge was dropped.
            if (r_edge_cnt == EDGE_MAX) r_sat      <= 1'b1;
            else                        r_edge_cnt <= r_edge_cnt + 1'b1;
          end
        end
        S_LATCH: begin
          r_freq     <= r_edge_cnt;
          r_overflow <= r_sat;
          r_valid    <= 1'b1;
          r_gate_cnt <= '0;
          r_sat      <= 1'b0;
          // An edge arriving on the latch cycle opens the next window.
          r_edge_cnt <= COUNT_W'(w_rise);
        end
        default: begin
          r_gate_cnt <= '0;
          r_edge_cnt <= '0;
          r_sat      <= 1'b0;
        end
      endcase
    end
  end

  assign freq     = r_freq;
  assign valid    = r_valid;
  assign overflow = r_overflow;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_freq_meter.sv
`timescale 1ns/1ps
// tb_freq_meter: two freq_meter instances (27-bit and 4-bit counters) share
// one stimulus stream; a window-level model predicts every output each cycle.
module tb_freq_meter;

  localparam int     GATE  = 1000;
  localparam int     W_A   = 27;
  localparam int     W_B   = 4;
  localparam longint MAX_A = (64'd1 << W_A) - 1;
  localparam longint MAX_B = (64'd1 << W_B) - 1;

  logic           clk    = 1'b0;
  logic           reset  = 1'b1;
  logic           enable = 1'b1;
  logic           sig_in = 1'b0;
  logic [W_A-1:0] freq_a;
  logic           valid_a, ovf_a, busy_a;
  logic [W_B-1:0] freq_b;
  logic           valid_b, ovf_b, busy_b;

  int n_total = 0;
  int n_bad   = 0;

  freq_meter #(.GATE_CYCLES(GATE), .COUNT_W(W_A)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
    .freq(freq_a), .valid(valid_a), .overflow(ovf_a), .busy(busy_a)
  );

  freq_meter #(.GATE_CYCLES(GATE), .COUNT_W(W_B)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
    .freq(freq_b), .valid(valid_b), .overflow(ovf_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint got, input longint want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- sig_in generator (changes only on negedge) -------------
  typedef enum int {G_HOLD, G_PERIOD, G_RAND, G_MANUAL} gen_e;
  gen_e gen_mode     = G_PERIOD;
  int   half_period  = 3;
  bit   hold_level   = 1'b0;
  bit   manual_level = 1'b0;
  int   run_left     = 1;
  int   edges_driven = 0;

  always @(negedge clk) begin
    logic nxt;
    nxt = sig_in;
    case (gen_mode)
      G_HOLD:   nxt = hold_level;
      G_MANUAL: nxt = manual_level;
      default: begin
        if (run_left <= 1) begin
          nxt      = ~sig_in;
          run_left = (gen_mode == G_RAND) ? int'($urandom_range(12, 2)) : half_period;
        end else begin
          run_left--;
        end
      end
    endcase
    if (nxt && !sig_in) edges_driven++;
    sig_in = nxt;
  end

  // ---------------- window-level reference model + per-cycle compare -------
  // A window is GATE counting cycles (positions 0..GATE-1) plus one closing
  // cycle (position GATE). A level change seen at clk edge k is credited to
  // the cycle ending at edge k+2; the first three post-reset samples only
  // prime the pipeline.
  bit     samp[$];
  int     m_pos    = -1;
  longint m_acc    = 0;
  bit     m_valid  = 1'b0;
  longint m_freq_a = 0;
  longint m_freq_b = 0;
  bit     m_ovf_a  = 1'b0;
  bit     m_ovf_b  = 1'b0;

  always @(posedge clk) begin
    bit rise;
    bit m_busy;
    int n;
    rise = 1'b0;
    if (reset) begin
      samp.delete();
      m_pos = -1; m_acc = 0; m_valid = 1'b0;
      m_freq_a = 0; m_freq_b = 0; m_ovf_a = 1'b0; m_ovf_b = 1'b0;
    end else begin
      samp.push_back(sig_in);
      n = samp.size();
      if (n >= 4) rise = samp[n-3] && !samp[n-4];
      m_valid = 1'b0;
      if (m_pos < 0) begin
        if (enable) begin m_pos = 0; m_acc = 0; end
      end else if (m_pos < GATE) begin
        if (!enable) m_pos = -1;
        else begin
          if (rise) m_acc++;
          m_pos++;
        end
      end else begin
        m_freq_a = (m_acc > MAX_A) ? MAX_A : m_acc;
        m_freq_b = (m_acc > MAX_B) ? MAX_B : m_acc;
        m_ovf_a  = (m_acc > MAX_A);
        m_ovf_b  = (m_acc > MAX_B);
        m_valid  = 1'b1;
        m_acc    = rise ? 1 : 0;
        m_pos    = enable ? 0 : -1;
      end
    end
    m_busy = (m_pos >= 0);
    #1;
    check("freq_a", longint'(freq_a), m_freq_a);
    check("freq_b", longint'(freq_b), m_freq_b);
    check("flags{va,vb,ba,bb,oa,ob}",
          longint'({valid_a, valid_b, busy_a, busy_b, ovf_a, ovf_b}),
          longint'({m_valid, m_valid, m_busy, m_busy, m_ovf_a, m_ovf_b}));
  end

  // ---------------- helpers -------------------------------------------------
  // Returns the number of rising clk edges waited until valid is seen.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!valid_a && cyc < 1200);
    check("valid_seen", longint'(valid_a), 1);
  endtask

  task automatic check_all_zero(input string name);
    check(name, longint'({freq_a, freq_b, valid_a, valid_b, ovf_a, ovf_b, busy_a, busy_b}), 0);
  endtask

  // ---------------- directed + random scenarios -----------------------------
  initial begin
    int     cyc;
    int     base;
    longint w1;
    longint w2;

    // Reset held 100 ns with enable high and sig_in toggling.
    #1;
    check_all_zero("reset_outputs_t1");
    repeat (10) @(negedge clk);
    reset = 1'b0;
    wait_valid(cyc);
    check("first_valid_latency", cyc, 1002);

    // 10-clk period, three consecutive windows.
    gen_mode = G_PERIOD; half_period = 5;
    wait_valid(cyc);
    for (int w = 0; w < 3; w++) begin
      wait_valid(cyc);
      check("p10_window_len", cyc, 1001);
      check("p10_freq_in_99_101", longint'(freq_a >= 99 && freq_a <= 101), 1);
      check("p10_ovf", longint'(ovf_a), 0);
    end

    // Constant levels give zero.
    gen_mode = G_HOLD; hold_level = 1'b0;
    wait_valid(cyc); wait_valid(cyc);
    check("hold0_freq", longint'(freq_a), 0);
    check("hold0_ovf", longint'(ovf_a), 0);
    hold_level = 1'b1;
    wait_valid(cyc); wait_valid(cyc);
    check("hold1_freq", longint'(freq_a), 0);

    // 4-clk period saturates the 4-bit instance, then an idle window clears it.
    gen_mode = G_PERIOD; half_period = 2;
    wait_valid(cyc); wait_valid(cyc);
    check("sat_freq_b", longint'(freq_b), 15);
    check("sat_ovf_b", longint'(ovf_b), 1);
    check("sat_freq_a_250_251", longint'(freq_a >= 250 && freq_a <= 251), 1);
    check("sat_ovf_a", longint'(ovf_a), 0);
    gen_mode = G_HOLD; hold_level = 1'b0;
    wait_valid(cyc); wait_valid(cyc);
    check("unsat_freq_b", longint'(freq_b), 0);
    check("unsat_ovf_b", longint'(ovf_b), 0);

    // Abort at gate count 500, idle for 20 clk, restart.
    gen_mode = G_RAND;
    wait_valid(cyc);
    repeat (500) @(posedge clk);
    @(negedge clk) enable = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", longint'(busy_a), 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("abort_no_valid", longint'(valid_a), 0);
      check("abort_idle_busy", longint'(busy_a), 0);
    end
    @(negedge clk) enable = 1'b1;
    wait_valid(cyc);
    // Edge 1 enters the count phase; the window closes 1001 clk later.
    check("restart_latency", cyc, 1002);

    // An edge whose rise lands on the closing cycle goes to the next window.
    gen_mode = G_MANUAL; manual_level = 1'b0;
    wait_valid(cyc); wait_valid(cyc);
    base = edges_driven;
    for (int p = 0; p < 5; p++) begin
      manual_level = 1'b1; repeat (3) @(posedge clk);
      manual_level = 1'b0; repeat (3) @(posedge clk);
    end
    repeat (968) @(posedge clk);
    manual_level = 1'b1;
    wait_valid(cyc);
    check("latch_edge_gap", cyc, 3);
    w1 = longint'(freq_a);
    check("latch_win1_freq", w1, 5);
    manual_level = 1'b0;
    repeat (3) @(posedge clk);
    for (int p = 0; p < 3; p++) begin
      manual_level = 1'b1; repeat (3) @(posedge clk);
      manual_level = 1'b0; repeat (3) @(posedge clk);
    end
    wait_valid(cyc);
    w2 = longint'(freq_a);
    check("latch_win2_freq", w2, 4);
    check("latch_sum_edges", w1 + w2, longint'(edges_driven - base));

    // Random sig_in with random enable drops.
    gen_mode = G_RAND;
    for (int r = 0; r < 5; r++) begin
      repeat ($urandom_range(1500, 100)) @(posedge clk);
      @(negedge clk) enable = 1'b0;
      repeat ($urandom_range(30, 1)) @(negedge clk);
      enable = 1'b1;
    end
    wait_valid(cyc);

    // Mid-window reset with sig_in high across release.
    repeat (300) @(posedge clk);
    gen_mode = G_HOLD; hold_level = 1'b1;
    @(negedge clk) reset = 1'b1;
    #1;
    check_all_zero("reset_async_mid");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_valid(cyc);
    check("post_reset_latency", cyc, 1002);
    check("high_at_release_freq", longint'(freq_a), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
